// File: rtl/adf4351_ctrl.sv
// ADF4351 power-up sequencer: after an initial delay it shifts six 32-bit register words
// (R5 first, R0 last) over CLK/DATA/LE, then idles. Lock detect is brought back through a 2-flop synchronizer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | chip enabled, waiting INIT_DELAY clocks
// S_LOAD  | select word idx, first low cycle of bit 31
// S_SHIFT | CLK low / high phases for each bit, MSB first
// S_LATCH | CLK low hold, LE pulse, gap (one CLK_DIV each)
// S_DONE  | all words written, outputs parked until reset
module adf4351_ctrl #(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned INIT_DELAY = 500,
    parameter logic [31:0] REG5       = 32'h0058_0005,
    parameter logic [31:0] REG4       = 32'h008C_803C,
    parameter logic [31:0] REG3       = 32'h0000_04B3,
    parameter logic [31:0] REG2       = 32'h1800_6E42,
    parameter logic [31:0] REG1       = 32'h0800_8011,
    parameter logic [31:0] REG0       = 32'h0050_0000
) (
    input  logic clk_50,
    input  logic rst,
    output logic vco_clk,
    output logic vco_data,
    output logic vco_le,
    output logic vco_ce,
    input  logic vco_ld,
    output logic prog_done,
    output logic pll_locked
);

    typedef enum logic [2:0] {S_INIT, S_LOAD, S_SHIFT, S_LATCH, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [2:0]  idx_q, idx_d;
    logic        hi_q, hi_d;
    logic [1:0]  lph_q, lph_d;
    logic        clk_q, clk_d;
    logic        data_q, data_d;
    logic        le_q, le_d;
    logic        ce_q, ce_d;
    logic        done_q, done_d;
    logic        ld_meta_q, ld_sync_q;
    logic [31:0] word_nxt;

    function automatic logic [31:0] word_sel(input logic [2:0] idx);
        case (idx)
            3'd0:    return REG5;
            3'd1:    return REG4;
            3'd2:    return REG3;
            3'd3:    return REG2;
            3'd4:    return REG1;
            default: return REG0;
        endcase
    endfunction

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= INIT_DELAY - 32'd1;
            bit_q   <= '0;
            idx_q   <= '0;
            hi_q    <= 1'b0;
            lph_q   <= '0;
            clk_q   <= 1'b0;
            data_q  <= 1'b0;
            le_q    <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            lph_q   <= lph_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            le_q    <= le_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            ld_meta_q <= 1'b0;
            ld_sync_q <= 1'b0;
        end else begin
            ld_meta_q <= vco_ld;
            ld_sync_q <= ld_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        lph_d   = lph_q;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == 32'd0) state_d = S_LOAD;
                else                cnt_d   = cnt_q - 32'd1;
            end
            // LOAD is the first cycle of bit 31's low phase, so SHIFT only owes CLK_DIV-1 more.
            S_LOAD: begin
                state_d = S_SHIFT;
                bit_d   = 5'd31;
                if (CLK_DIV == 1) begin
                    hi_d  = 1'b1;
                    cnt_d = 32'd0;
                end else begin
                    hi_d  = 1'b0;
                    cnt_d = CLK_DIV - 32'd2;
                end
            end
            S_SHIFT: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    cnt_d = CLK_DIV - 32'd1;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else begin
                        hi_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            state_d = S_LATCH;
                            lph_d   = 2'd0;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end
                end
            end
            S_LATCH: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    cnt_d = CLK_DIV - 32'd1;
                    if (lph_q != 2'd2) begin
                        lph_d = lph_q + 2'd1;
                    end else if (idx_q != 3'd5) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: ;
            default: state_d = S_INIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        word_nxt = word_sel(idx_d);
        clk_d    = (state_d == S_SHIFT) && hi_d;
        le_d     = (state_d == S_LATCH) && (lph_d == 2'd1);
        done_d   = (state_d == S_DONE);
        ce_d     = 1'b1;
        data_d   = data_q;
        case (state_d)
            S_LOAD:  data_d = word_nxt[31];
            S_SHIFT: data_d = word_nxt[bit_d];
            S_LATCH: data_d = data_q;
            default: data_d = 1'b0;
        endcase
    end

    assign vco_clk    = clk_q;
    assign vco_data   = data_q;
    assign vco_le     = le_q;
    assign vco_ce     = ce_q;
    assign prog_done  = done_q;
    assign pll_locked = ld_sync_q;

endmodule

// File: tb/tb_adf4351_ctrl.sv
// Directed bench for adf4351_ctrl: serial words, SCLK/LE timing, done timing, mid-word reset, lock sync.
`timescale 1ns/1ps
module tb_adf4351_ctrl;

    localparam int C = 25;
    localparam int D = 500;
    localparam int DONE_CYC = D + 6 * 67 * C;

    logic clk_50 = 1'b0;
    logic rst, vco_ld;
    logic vco_clk, vco_data, vco_le, vco_ce, prog_done, pll_locked;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] expw [6] = '{32'h0058_0005, 32'h008C_803C, 32'h0000_04B3,
                              32'h1800_6E42, 32'h0800_8011, 32'h0050_0000};

    int          wcnt, nbits, hi_len, le_len, last_rise, first_rise, act_cnt;
    logic [31:0] shreg;
    logic        p_clk, p_le, p_data;
    logic        ld_prev;

    adf4351_ctrl dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .vco_clk   (vco_clk),
        .vco_data  (vco_data),
        .vco_le    (vco_le),
        .vco_ce    (vco_ce),
        .vco_ld    (vco_ld),
        .prog_done (prog_done),
        .pll_locked(pll_locked)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Serial-interface monitor sampled on the falling system-clock edge.
    always @(negedge clk_50) begin
        if (rst) begin
            wcnt = 0; nbits = 0; hi_len = 0; le_len = 0; last_rise = 0; first_rise = 0;
            shreg = '0; p_clk = 1'b0; p_le = 1'b0; p_data = 1'b0;
        end else begin
            if (vco_clk && !p_clk) begin
                act_cnt++;
                shreg = {shreg[30:0], vco_data};
                nbits++;
                check("le_low_shift", {31'd0, vco_le}, 32'd0);
                if (nbits > 1) check("sclk_period", last_rise == 0 ? 0 : cyc - last_rise, 2 * C);
                last_rise = cyc;
                if (first_rise == 0) first_rise = cyc;
                hi_len = 1;
            end else if (vco_clk && p_clk) begin
                hi_len++;
                check("data_stable_hi", {31'd0, vco_data}, {31'd0, p_data});
            end else if (!vco_clk && p_clk) begin
                check("sclk_high_len", hi_len, C);
            end
            if (vco_le && !p_le) begin
                act_cnt++;
                check("le_clk_low", {31'd0, vco_clk}, 32'd0);
                check("bits_per_word", nbits, 32);
                if (wcnt < 6) check("word", shreg, expw[wcnt]);
                wcnt++;
                nbits = 0;
                le_len = 1;
            end else if (vco_le && p_le) begin
                le_len++;
            end else if (!vco_le && p_le) begin
                check("le_width", le_len, C);
            end
            p_clk = vco_clk; p_le = vco_le; p_data = vco_data;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_50);
    endtask

    task automatic ld_test(input logic val);
        @(negedge clk_50);
        vco_ld = val;
        @(negedge clk_50);
        check("ld_sync_1clk", {31'd0, pll_locked}, {31'd0, ld_prev});
        @(negedge clk_50);
        check("ld_sync_2clk", {31'd0, pll_locked}, {31'd0, val});
        ld_prev = val;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {26'd0, vco_clk, vco_data, vco_le, vco_ce, prog_done, pll_locked}, 32'd0);
    endtask

    task automatic release_rst;
        @(negedge clk_50);
        rst = 1'b0;
        #1 check("ce_before_first_clk", {31'd0, vco_ce}, 32'd0);
        @(negedge clk_50);
        check("ce_first_clk", {31'd0, vco_ce}, 32'd1);
    endtask

    task automatic run_to_done(input string tag);
        int snap;
        while (!prog_done && cyc < DONE_CYC + 200) @(negedge clk_50);
        check({tag, "_done_cyc"}, cyc, DONE_CYC);
        check({tag, "_words"}, wcnt, 6);
        check({tag, "_first_sclk"}, first_rise, D + C);
        check({tag, "_done_outs"}, {29'd0, vco_clk, vco_le, vco_data}, 32'd0);
        snap = act_cnt;
        wait_cyc(12500);
        check({tag, "_idle_activity"}, act_cnt - snap, 0);
        check({tag, "_done_hold"}, {30'd0, prog_done, vco_ce}, 32'd3);
    endtask

    initial begin
        act_cnt = 0;
        ld_prev = 1'b0;
        rst = 1'b1;
        vco_ld = 1'b0;
        repeat (100) @(negedge clk_50);
        check_reset_outputs("reset_outputs");

        // Run 1: full sequence with lock-detect toggles during INIT and SHIFT.
        release_rst();
        ld_test(1'b1);
        wait_cyc(100);
        check("no_sclk_in_init", act_cnt, 0);
        wait_cyc(D - 5);
        check("no_sclk_before_delay", act_cnt, 0);
        wait_cyc(700);
        ld_test(1'b0);
        wait_cyc(2000);
        ld_test(1'b1);
        run_to_done("run1");

        // Run 2: abort in the middle of the third word.
        @(negedge clk_50);
        rst = 1'b1;
        repeat (5) @(negedge clk_50);
        release_rst();
        while (!(wcnt == 2 && nbits == 10) && cyc < 5000) @(negedge clk_50);
        check("reached_word3", {wcnt[15:0], nbits[15:0]}, {16'd2, 16'd10});
        #3 rst = 1'b1;
        #1 check_reset_outputs("async_reset_outputs");
        repeat (3) @(negedge clk_50);
        check_reset_outputs("held_reset_outputs");

        // Run 3: full restart from REG5.
        release_rst();
        run_to_done("run3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adf4351_ctrl.md
Name: adf4351_ctrl

Overview:
- Power-up configuration sequencer for an ADF4351 wideband PLL/VCO synthesizer.
- After reset it waits an initial delay, then shifts six 32-bit words (R5 first, R0 last) MSB-first over the chip's 3-wire serial interface (CLK/DATA/LE) and then idles.
- It drives chip enable and reports a synchronized lock-detect status back to the SDR front-end logic.

Parameters:
- CLK_DIV, 25: system clocks per SCLK half-period (50 MHz / 50 = 1 MHz SCLK).
- INIT_DELAY, 500: clocks from reset release to first SCLK activity (10 us).
- REG5, 32'h0058_0005: word sent 1st (address bits [2:0]=101).
- REG4, 32'h008C_803C: word sent 2nd (100).
- REG3, 32'h0000_04B3: word sent 3rd (011).
- REG2, 32'h1800_6E42: word sent 4th (010).
- REG1, 32'h0800_8011: word sent 5th (001).
- REG0, 32'h0050_0000: word sent 6th (000).

Ports:
- clk_50 input 1: 50 MHz system clock; all logic on rising edge.
- rst input 1: asynchronous, active-high reset.
- vco_clk output 1: serial clock to ADF4351 CLK; idles low.
- vco_data output 1: serial data to ADF4351 DATA; registered.
- vco_le output 1: load enable; rising edge latches the 32-bit shift register into the device.
- vco_ce output 1: chip enable.
- vco_ld input 1: lock detect from device; asynchronous, high = locked.
- prog_done output 1: high once all six words are written.
- pll_locked output 1: vco_ld after a two-flop synchronizer.

Behaviour:
- Reset values while rst high: vco_clk=0, vco_data=0, vco_le=0, vco_ce=0, prog_done=0, pll_locked=0, all counters and FSM cleared.
- Reset asserted mid-transfer aborts immediately; the full sequence restarts from INIT after release.
- FSM states and transitions:
  - INIT: vco_ce=1 from the first clock after reset release; count INIT_DELAY clocks, then go to LOAD.
  - LOAD: select word by index 0..5 (REG5..REG0); bit counter=31; go to SHIFT.
  - SHIFT, per bit: drive vco_data=word[bit] with vco_clk low for CLK_DIV clocks, then vco_clk high for CLK_DIV clocks.
  - Data changes only while vco_clk is low, so it is stable CLK_DIV clocks before each rising edge (device samples on rising edge).
  - After bit 0's high phase, vco_clk returns low; go to LATCH.
  - LATCH: hold vco_clk low CLK_DIV clocks, vco_le=1 for CLK_DIV clocks, vco_le=0, then gap CLK_DIV clocks.
  - After LATCH: if word index<5, increment and go to LOAD; else go to DONE.
  - DONE: prog_done=1, vco_clk=0, vco_le=0, vco_data=0, vco_ce stays 1; remain until reset.
- vco_le is low for the whole of every word shift; exactly 32 rising vco_clk edges between consecutive vco_le pulses.
- Cycle budget: per word 64*CLK_DIV + 3*CLK_DIV = 1675 clocks; total = INIT_DELAY + 6*1675 = 10550 clocks (211 us) at defaults.
- pll_locked = vco_ld delayed 2 clk_50 cycles; independent of FSM state; no effect on sequencing.
- Parameters must be honored for any CLK_DIV>=1 and INIT_DELAY>=1.

Test Plan:
- rst=1 for 2 us, release; check vco_ce rises the first clock after release and no vco_clk edge occurs before 500 clocks (10 us).
- Capture vco_data on each vco_clk rising edge, framed by vco_le pulses -> 6 words in order: 0x00580005, 0x008C803C, 0x000004B3, 0x18006E42, 0x08008011, 0x00500000.
- Measure vco_clk -> period 1000 ns, 50% duty; vco_data never changes while vco_clk high; vco_le high 500 ns, only while vco_clk low; exactly 32 edges per word.
- prog_done rises at 211 us ±1 clock after release; afterward no further vco_clk/vco_le activity through 250 us.
- Pulse rst mid-word 3 -> outputs return to reset values asynchronously; after release the sequence restarts with REG5.
- Toggle vco_ld -> pll_locked follows after 2 clocks, any FSM state; sequence timing unaffected.
